// File: rtl/jk_pkg.sv
// Shared mode encodings for the JK register bank.
package jk_pkg;

    typedef logic [1:0] jk_mode_t;

    localparam jk_mode_t MODE_JK = 2'b00;
    localparam jk_mode_t MODE_T  = 2'b01;
    localparam jk_mode_t MODE_D  = 2'b10;
    localparam jk_mode_t MODE_SR = 2'b11;

endpackage

// File: rtl/jk_bit_next.sv
// Combinational next-state for one flip-flop of the bank, selectable between
// JK, T, D and SR behaviour.
module jk_bit_next
    import jk_pkg::*;
(
    input  jk_mode_t mode,
    input  logic     j,
    input  logic     k,
    input  logic     q,
    output logic     q_next,
    output logic     sr_bad
);

    always_comb begin
        q_next = q;
        sr_bad = 1'b0;
        case (mode)
            MODE_JK: begin
                case ({j, k})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   q_next = ~q;
                    default: q_next = q;
                endcase
            end
            MODE_T:  q_next = j ? ~q : q;
            MODE_D:  q_next = j;
            MODE_SR: begin
                // S=R=1 is illegal: keep the bit and report it upstream
                case ({j, k})
                    2'b10:   q_next = 1'b1;
                    2'b01:   q_next = 1'b0;
                    default: q_next = q;
                endcase
                sr_bad = j & k;
            end
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH self-holding flip-flops with per-edge mode selection, parallel
// load, registered change/error pulses and a saturating change counter.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clr_count,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             changed,
    output logic             sr_err,
    output logic [CNT_W-1:0] chg_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qbar_q, qbar_d;
    logic             changed_q, changed_d;
    logic             sr_err_q, sr_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] bit_next;
    logic [WIDTH-1:0] sr_bad;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_bit_next u_bit (
            .mode   (mode),
            .j      (j[i]),
            .k      (k[i]),
            .q      (q_q[i]),
            .q_next (bit_next[i]),
            .sr_bad (sr_bad[i])
        );
    end

    always_comb begin
        q_d      = q_q;
        sr_err_d = 1'b0;
        if (load) begin
            q_d = load_data;
        end else if (en) begin
            q_d      = bit_next;
            sr_err_d = |sr_bad;
        end
        qbar_d    = ~q_d;
        changed_d = (q_d != q_q);

        // A clear coinciding with a change counts that change as the first event
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = changed_d ? CNT_ONE : '0;
        end else if (changed_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            q_q       <= RESET_VAL;
            qbar_q    <= ~RESET_VAL;
            changed_q <= 1'b0;
            sr_err_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            q_q       <= q_d;
            qbar_q    <= qbar_d;
            changed_q <= changed_d;
            sr_err_q  <= sr_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign q         = q_q;
    assign qbar      = qbar_q;
    assign changed   = changed_q;
    assign sr_err    = sr_err_q;
    assign chg_count = cnt_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank: directed vectors queue their expected
// post-edge state, and a monitor compares every output after each edge.
module tb_jk_reg_bank;
    import jk_pkg::*;

    typedef struct packed {
        logic [7:0] q;
        logic       ch;
        logic       sr;
        logic [7:0] cnt;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       en;
    logic       load;
    logic [7:0] load_data;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic       clr_count;
    logic [7:0] q;
    logic [7:0] qbar;
    logic       changed;
    logic       sr_err;
    logic [7:0] chg_count;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   stim_done = 1'b0;

    jk_reg_bank #(
        .WIDTH     (8),
        .CNT_W     (8),
        .RESET_VAL (8'hA5)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en),
        .load      (load),
        .load_data (load_data),
        .mode      (mode),
        .j         (j),
        .k         (k),
        .clr_count (clr_count),
        .q         (q),
        .qbar      (qbar),
        .changed   (changed),
        .sr_err    (sr_err),
        .chg_count (chg_count)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
        end
    endtask

    // Drive one edge's worth of inputs on the falling edge and queue what the
    // bank must show after the following rising edge.
    task automatic apply_stimulus(
        input logic       rn,
        input logic       ld,
        input logic [7:0] ld_data,
        input logic       e,
        input logic [1:0] m,
        input logic [7:0] jj,
        input logic [7:0] kk,
        input logic       clr,
        input logic [7:0] eq,
        input logic       ech,
        input logic       esr,
        input logic [7:0] ecnt
    );
        exp_t x;
        @(negedge clock);
        reset_n   = rn;
        load      = ld;
        load_data = ld_data;
        en        = e;
        mode      = m;
        j         = jj;
        k         = kk;
        clr_count = clr;
        x.q   = eq;
        x.ch  = ech;
        x.sr  = esr;
        x.cnt = ecnt;
        sb.push_back(x);
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output("q", q, e.q);
            check_output("qbar", qbar, ~e.q);
            check_output("changed", {7'd0, changed}, {7'd0, e.ch});
            check_output("sr_err", {7'd0, sr_err}, {7'd0, e.sr});
            check_output("chg_count", chg_count, e.cnt);
        end
    end

    initial begin
        int c;
        reset_n   = 1'b0;
        en        = 1'b0;
        load      = 1'b0;
        load_data = 8'h00;
        mode      = MODE_JK;
        j         = 8'h00;
        k         = 8'h00;
        clr_count = 1'b0;

        //             rn ld data  en mode     j      k      clr  q      ch sr cnt
        apply_stimulus(0, 0, 8'h00, 0, MODE_JK, 8'h00, 8'h00, 0, 8'hA5, 0, 0, 8'd0);
        apply_stimulus(0, 0, 8'h00, 0, MODE_JK, 8'h00, 8'h00, 0, 8'hA5, 0, 0, 8'd0);
        apply_stimulus(1, 0, 8'h00, 0, MODE_JK, 8'hFF, 8'h00, 0, 8'hA5, 0, 0, 8'd0);
        apply_stimulus(1, 1, 8'h00, 0, MODE_JK, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'd1);

        apply_stimulus(1, 0, 8'h00, 1, MODE_JK, 8'hF0, 8'h00, 0, 8'hF0, 1, 0, 8'd2);
        apply_stimulus(1, 0, 8'h00, 1, MODE_JK, 8'hFF, 8'hFF, 0, 8'h0F, 1, 0, 8'd3);
        apply_stimulus(1, 0, 8'h00, 1, MODE_JK, 8'h00, 8'h0F, 0, 8'h00, 1, 0, 8'd4);
        apply_stimulus(1, 0, 8'h00, 1, MODE_JK, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'd4);

        for (int n = 1; n <= 300; n++) begin
            c = 4 + n;
            apply_stimulus(1, 0, 8'h00, 1, MODE_T, 8'h01, 8'hFF, 0,
                           (n % 2 == 1) ? 8'h01 : 8'h00, 1, 0,
                           (c > 255) ? 8'd255 : 8'(c));
        end

        apply_stimulus(1, 0, 8'h00, 1, MODE_SR, 8'h03, 8'h02, 0, 8'h01, 1, 1, 8'd255);
        apply_stimulus(1, 0, 8'h00, 1, MODE_SR, 8'h00, 8'h01, 0, 8'h00, 1, 0, 8'd255);
        apply_stimulus(1, 0, 8'h00, 0, MODE_SR, 8'hFF, 8'hFF, 0, 8'h00, 0, 0, 8'd255);
        apply_stimulus(1, 1, 8'h00, 1, MODE_SR, 8'hFF, 8'hFF, 0, 8'h00, 0, 0, 8'd255);

        apply_stimulus(1, 0, 8'h00, 0, MODE_JK, 8'h00, 8'h00, 1, 8'h00, 0, 0, 8'd0);
        apply_stimulus(1, 1, 8'h3C, 1, MODE_JK, 8'hFF, 8'hFF, 0, 8'h3C, 1, 0, 8'd1);
        apply_stimulus(1, 1, 8'h3C, 1, MODE_JK, 8'hFF, 8'hFF, 0, 8'h3C, 0, 0, 8'd1);

        apply_stimulus(1, 0, 8'h00, 1, MODE_D,  8'hFF, 8'h00, 0, 8'hFF, 1, 0, 8'd2);
        apply_stimulus(1, 0, 8'h00, 1, MODE_D,  8'hFF, 8'h5A, 0, 8'hFF, 0, 0, 8'd2);
        apply_stimulus(1, 0, 8'h00, 1, MODE_D,  8'hC3, 8'h00, 1, 8'hC3, 1, 0, 8'd1);

        apply_stimulus(0, 0, 8'h00, 1, MODE_T,  8'hFF, 8'h00, 0, 8'hA5, 0, 0, 8'd0);
        apply_stimulus(0, 1, 8'h00, 1, MODE_T,  8'hFF, 8'h00, 0, 8'hA5, 0, 0, 8'd0);
        apply_stimulus(1, 0, 8'h00, 1, MODE_T,  8'hFF, 8'h00, 0, 8'h5A, 1, 0, 8'd1);
        apply_stimulus(1, 0, 8'h00, 1, MODE_T,  8'h0F, 8'hF0, 0, 8'h55, 1, 0, 8'd2);

        @(negedge clock);
        en   = 1'b0;
        load = 1'b0;
        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        repeat (3) @(posedge clock);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL timeout: got no completion expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
